// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus: redirect/stall control, ROM port and IF/ID outputs
// AlignFault is present only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_unit_if;
  logic        Stall;
  logic        RedirectValid;
  logic [31:0] RedirectTarget;
  logic [31:0] FetchAddress;
  logic [31:0] FetchInstruction;
  logic        IfIdValid;
  logic [31:0] IfIdInstruction;
  logic [31:0] IfIdPc;
  logic [31:0] IfIdPcPlus4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        AlignFault;

  modport master (
    input  Stall, RedirectValid, RedirectTarget, FetchInstruction,
    output FetchAddress, IfIdValid, IfIdInstruction, IfIdPc, IfIdPcPlus4, AlignFault
  );

  modport slave (
    output Stall, RedirectValid, RedirectTarget, FetchInstruction,
    input  FetchAddress, IfIdValid, IfIdInstruction, IfIdPc, IfIdPcPlus4, AlignFault
  );
`else
  modport master (
    input  Stall, RedirectValid, RedirectTarget, FetchInstruction,
    output FetchAddress, IfIdValid, IfIdInstruction, IfIdPc, IfIdPcPlus4
  );

  modport slave (
    output Stall, RedirectValid, RedirectTarget, FetchInstruction,
    input  FetchAddress, IfIdValid, IfIdInstruction, IfIdPc, IfIdPcPlus4
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, IF/ID pipeline register, BOOT/RUN(/FAULT) FSM
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic   Clock,
  input  logic   Reset,
  fetch_unit_if.master bus
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic [31:0] pc_plus4;
  logic        redirect_live;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault_q, fault_d;
`endif

  assign pc_plus4          = pc_q + 32'd4;
  assign bus.FetchAddress  = pc_q;
  assign bus.IfIdValid       = valid_q;
  assign bus.IfIdInstruction = inst_q;
  assign bus.IfIdPc          = ipc_q;
  assign bus.IfIdPcPlus4     = ipc4_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.AlignFault      = fault_q;
`endif

  // A redirect is honoured in BOOT and RUN alike; FAULT ignores it.
  assign redirect_live = bus.RedirectValid && (state_q == BOOT || state_q == RUN);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif

    case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b0;
      end
      RUN: begin
        if (!bus.RedirectValid && !bus.Stall) begin
          inst_d  = bus.FetchInstruction;
          ipc_d   = pc_q;
          ipc4_d  = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      FAULT: begin
        valid_d = 1'b0;
      end
`endif
      default: begin
        state_d = BOOT;
        valid_d = 1'b0;
      end
    endcase

    // Flush only clears the valid bit; the IF/ID payload keeps its last value.
    if (redirect_live) begin
      valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (bus.RedirectTarget[1:0] != 2'b00) begin
        state_d = FAULT;
        fault_d = 1'b1;
      end else begin
        pc_d = bus.RedirectTarget;
      end
`else
      pc_d = bus.RedirectTarget & 32'hFFFF_FFFC;
`endif
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      inst_q  <= 32'd0;
      ipc_q   <= 32'd0;
      ipc4_q  <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (default build and FETCH_ALIGN_CHECK_EN build)
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } fetch_t;

  logic Clock;
  logic Reset;

  fetch_unit_if a_if ();
  fetch_unit_if b_if ();

  fetch_unit #(.RESET_PC(32'h00000000)) dut_a (.Clock(Clock), .Reset(Reset), .bus(a_if));
  fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut_b (.Clock(Clock), .Reset(Reset), .bus(b_if));

  function automatic logic [31:0] rom(input logic [31:0] addr);
    case (addr)
      32'h00000000: rom = 32'h00432020;
      32'h00000004: rom = 32'h8C440004;
      default:      rom = 32'hA5000000 ^ addr;
    endcase
  endfunction

  assign a_if.FetchInstruction = rom(a_if.FetchAddress);
  assign b_if.FetchInstruction = rom(b_if.FetchAddress);
  assign b_if.Stall            = 1'b0;
  assign b_if.RedirectValid    = 1'b0;
  assign b_if.RedirectTarget   = 32'd0;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [31:0] m_pc, m_inst, m_ipc, m_ipc4;
  logic        m_valid;
  bit          m_boot;
  fetch_t      sb[$];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc    = 32'd0;
    m_valid = 1'b0;
    m_inst  = 32'd0;
    m_ipc   = 32'd0;
    m_ipc4  = 32'd0;
    m_boot  = 1'b1;
    sb.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_fetch_addr"}, a_if.FetchAddress, 32'd0);
    check_eq({tag, "_valid"}, 32'(a_if.IfIdValid), 32'd0);
    check_eq({tag, "_inst"}, a_if.IfIdInstruction, 32'd0);
    check_eq({tag, "_ipc"}, a_if.IfIdPc, 32'd0);
    check_eq({tag, "_ipc4"}, a_if.IfIdPcPlus4, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq({tag, "_align_fault"}, 32'(a_if.AlignFault), 32'd0);
`endif
  endtask

  // Drives one cycle of stimulus from just after a falling edge and checks DUT A after the next rising edge.
  task automatic cycle(input logic st, input logic rv, input logic [31:0] tgt);
    bit     pushed;
    fetch_t e;
    a_if.Stall          = st;
    a_if.RedirectValid  = rv;
    a_if.RedirectTarget = tgt;
    check_eq("fetch_addr", a_if.FetchAddress, m_pc);
    pushed = 0;
    if (rv) begin
      m_pc    = tgt & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_boot  = 0;
    end else if (m_boot) begin
      m_valid = 1'b0;
      m_boot  = 0;
    end else if (!st) begin
      e.inst = rom(m_pc);
      e.pc   = m_pc;
      e.pc4  = m_pc + 32'd4;
      sb.push_back(e);
      m_pc   = m_pc + 32'd4;
      pushed = 1;
    end
    @(posedge Clock);
    @(negedge Clock);
    if (pushed) begin
      if (sb.size() == 0) begin
        check_eq("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e       = sb.pop_front();
        m_valid = 1'b1;
        m_inst  = e.inst;
        m_ipc   = e.pc;
        m_ipc4  = e.pc4;
      end
    end
    check_eq("ifid_valid", 32'(a_if.IfIdValid), 32'(m_valid));
    check_eq("ifid_inst", a_if.IfIdInstruction, m_inst);
    check_eq("ifid_pc", a_if.IfIdPc, m_ipc);
    check_eq("ifid_pc4", a_if.IfIdPcPlus4, m_ipc4);
  endtask

  initial begin
    logic [31:0] tgt;
    logic        st, rv;
`ifdef FETCH_ALIGN_CHECK_EN
    logic [31:0] pc_hold;
`endif
    Reset               = 1'b1;
    a_if.Stall          = 1'b0;
    a_if.RedirectValid  = 1'b0;
    a_if.RedirectTarget = 32'd0;
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    check_reset_values("reset");
    check_eq("b_reset_fetch_addr", b_if.FetchAddress, 32'hFFFFFFFC);
    Reset = 1'b0;

    // Boot cycle, then the two ROM words at 0x00 and 0x04.
    cycle(1'b0, 1'b0, 32'd0);
    check_eq("b_boot_valid", 32'(b_if.IfIdValid), 32'd0);
    check_eq("b_boot_fetch_addr", b_if.FetchAddress, 32'hFFFFFFFC);
    cycle(1'b0, 1'b0, 32'd0);
    check_eq("first_inst", a_if.IfIdInstruction, 32'h00432020);
    check_eq("first_pc4", a_if.IfIdPcPlus4, 32'h00000004);
    check_eq("b_wrap_ipc", b_if.IfIdPc, 32'hFFFFFFFC);
    check_eq("b_wrap_ipc4", b_if.IfIdPcPlus4, 32'h00000000);
    check_eq("b_wrap_fetch_addr", b_if.FetchAddress, 32'h00000000);
    check_eq("b_wrap_valid", 32'(b_if.IfIdValid), 32'd1);
    cycle(1'b0, 1'b0, 32'd0);
    check_eq("second_inst", a_if.IfIdInstruction, 32'h8C440004);
    check_eq("second_pc", a_if.IfIdPc, 32'h00000004);

    // Three stalled cycles at PC=0x08, then resume.
    repeat (3) cycle(1'b1, 1'b0, 32'd0);
    check_eq("stall_fetch_addr", a_if.FetchAddress, 32'h00000008);
    cycle(1'b0, 1'b0, 32'd0);
    check_eq("after_stall_pc", a_if.IfIdPc, 32'h00000008);

    // Redirect wins over stall.
    cycle(1'b1, 1'b1, 32'h0000002C);
    check_eq("redirect_valid", 32'(a_if.IfIdValid), 32'd0);
    check_eq("redirect_fetch_addr", a_if.FetchAddress, 32'h0000002C);
    cycle(1'b0, 1'b0, 32'd0);
    check_eq("redirect_ipc", a_if.IfIdPc, 32'h0000002C);
    check_eq("redirect_ifid_valid", 32'(a_if.IfIdValid), 32'd1);

    for (int i = 0; i < 60; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      tgt = $urandom & 32'h00000FFF;
`ifdef FETCH_ALIGN_CHECK_EN
      tgt = tgt & 32'hFFFF_FFFC;
`endif
      cycle(st, rv, tgt);
    end

`ifdef FETCH_ALIGN_CHECK_EN
    pc_hold             = m_pc;
    a_if.Stall          = 1'b0;
    a_if.RedirectValid  = 1'b1;
    a_if.RedirectTarget = 32'h0000002E;
    @(posedge Clock);
    @(negedge Clock);
    check_eq("fault_flag", 32'(a_if.AlignFault), 32'd1);
    check_eq("fault_pc_hold", a_if.FetchAddress, pc_hold);
    check_eq("fault_valid", 32'(a_if.IfIdValid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      a_if.Stall          = 1'(i % 2);
      a_if.RedirectValid  = 1'(i != 1);
      a_if.RedirectTarget = 32'h00000100;
      @(posedge Clock);
      @(negedge Clock);
      check_eq("fault_sticky_flag", 32'(a_if.AlignFault), 32'd1);
      check_eq("fault_sticky_pc", a_if.FetchAddress, pc_hold);
      check_eq("fault_sticky_valid", 32'(a_if.IfIdValid), 32'd0);
    end
`else
    cycle(1'b0, 1'b1, 32'h0000002E);
    check_eq("misaligned_masked_pc", a_if.FetchAddress, 32'h0000002C);
`endif

    // Clean restart, redirect during BOOT, then run up to PC=0x40 and stall there.
    a_if.Stall         = 1'b0;
    a_if.RedirectValid = 1'b0;
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    cycle(1'b0, 1'b1, 32'h00000038);
    check_eq("boot_redirect_pc", a_if.FetchAddress, 32'h00000038);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    check_eq("mid_stall_pc", a_if.FetchAddress, 32'h00000040);
    a_if.Stall = 1'b1;
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(negedge Clock);
    Reset = 1'b0;
    a_if.Stall = 1'b0;
    model_reset();
    repeat (4) cycle(1'b0, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port Clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Stall  input  1  decode cannot accept; hold the PC and IF/ID register.
REQ-005 SHALL have port RedirectValid  input  1  a taken branch, jump or jr is present this cycle.
REQ-006 SHALL have port RedirectTarget  input  32  next-PC byte address when RedirectValid=1.
REQ-007 SHALL have port FetchAddress  output  32  byte address to the combinational instruction ROM.
REQ-008 SHALL have port FetchInstruction  input  32  ROM word for FetchAddress, valid in the same cycle.
REQ-009 SHALL have port IfIdValid  output  1  the IF/ID register holds a real instruction.
REQ-010 SHALL have port IfIdInstruction  output  32  registered instruction word.
REQ-011 SHALL have port IfIdPc  output  32  registered address of IfIdInstruction.
REQ-012 SHALL have port IfIdPcPlus4  output  32  registered IfIdPc+4, for branch and jal targets.
REQ-013 SHALL have port AlignFault  output  1  sticky misaligned-redirect flag; present only when FETCH_ALIGN_CHECK_EN is defined.

Function
REQ-014 SHALL drive FetchAddress combinationally from the PC register, with zero latency to the ROM.
REQ-015 SHALL implement states BOOT, RUN and FAULT; FAULT exists only with FETCH_ALIGN_CHECK_EN.
REQ-016 SHALL leave reset in BOOT, spend exactly one cycle there with IfIdValid=0 and the PC unchanged, then enter RUN.
REQ-017 SHALL, in RUN with Stall=0 and RedirectValid=0, register FetchInstruction, PC and PC+4 into IF/ID, set IfIdValid=1 and set PC to PC+4.
REQ-018 SHALL, in RUN with Stall=1 and RedirectValid=0, hold the PC and all IF/ID outputs unchanged.
REQ-019 SHALL, in RUN with RedirectValid=1, load the PC from RedirectTarget and clear IfIdValid (flush), whatever the value of Stall.
REQ-020 SHALL give a redirect in BOOT the same treatment as REQ-019, and still move to RUN.
REQ-021 SHALL compute PC+4 modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000 with no flag.
REQ-022 SHALL leave IfIdInstruction, IfIdPc and IfIdPcPlus4 unchanged when it clears IfIdValid.
REQ-023 SHALL give one instruction of throughput per unstalled cycle, with a 1-cycle ROM-to-IF/ID latency.

Reset
REQ-024 SHALL, on Reset assertion and regardless of Clock, set PC=RESET_PC, IfIdValid=0, IfIdInstruction=0, IfIdPc=0, IfIdPcPlus4=0, AlignFault=0 and state=BOOT.
REQ-025 SHALL abort any in-progress fetch, stall or fault when Reset asserts mid-operation, and SHALL restart from REQ-016 after release.

Configuration
REQ-026 SHALL, with FETCH_ALIGN_CHECK_EN defined, enter FAULT when RedirectValid=1 and RedirectTarget[1:0]!=0, leaving the PC unchanged and setting AlignFault=1.
REQ-027 SHALL, in FAULT, hold IfIdValid=0, AlignFault=1 and the PC unchanged, ignore Stall and RedirectValid, and leave FAULT only on Reset.
REQ-028 SHALL, without FETCH_ALIGN_CHECK_EN, omit the AlignFault port and the FAULT state, and force RedirectTarget[1:0] to 2'b00 when loading the PC.

Verification
REQ-029 SHALL cover: ROM words 0x00432020@0x00 and 0x8C440004@0x04, release Reset -> BOOT cycle IfIdValid=0; next edge IfIdInstruction=0x00432020, IfIdPc=0x00, IfIdPcPlus4=0x04; next edge 0x8C440004, IfIdPc=0x04.
REQ-030 SHALL cover: Stall=1 for 3 cycles at PC=0x08 -> FetchAddress stays 0x08, IF/ID outputs frozen; after Stall=0, IfIdPc=0x08 on the next edge.
REQ-031 SHALL cover: RedirectValid=1, RedirectTarget=0x2C with Stall=1 -> next edge IfIdValid=0 and PC=0x2C; following edge IfIdPc=0x2C, IfIdValid=1.
REQ-032 SHALL cover: RESET_PC=32'hFFFFFFFC, run 2 cycles -> IfIdPc=0xFFFFFFFC with IfIdPcPlus4=0x00000000, then FetchAddress=0x00000000.
REQ-033 SHALL cover: with the macro, redirect to 0x0000002E -> AlignFault=1, PC holds, IfIdValid stays 0 through later redirects; without the macro, the same redirect gives PC=0x2C.
REQ-034 SHALL cover: Reset asserted asynchronously mid-stall at PC=0x40 -> outputs go to the REQ-024 values before the next Clock edge.
